// File: rtl/pc_fetch.sv
// Program-counter and instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the word until retired, then advances or jumps. Optional retire counter: RETIRE_CNT_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] offset,
  input  logic        jalr_en,
  input  logic [31:0] jalr_target,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        misalign,
`ifdef RETIRE_CNT_EN
  output logic [31:0] instret,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req stays high with imem_addr stable until an edge sees imem_ack=1;
  // that edge transfers imem_rdata. The core retires the presented word with advance=1
  // while instr_valid=1; advance and ack are ignored in every other state.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] next_pc;

`ifdef RETIRE_CNT_EN
  logic [31:0] instret_q, instret_d;
`endif

  // Bit 0 of the JALR target is architecturally discarded.
  logic unused_jalr_bit0;
  assign unused_jalr_bit0 = jalr_target[0];

  assign next_pc = jalr_en ? {jalr_target[31:1], 1'b0} : pc_q + offset;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
`ifdef RETIRE_CNT_EN
    instret_d     = instret_q;
`endif
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
`ifdef RETIRE_CNT_EN
          instret_d     = instret_q + 32'd1;
`endif
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            state_d = REQ;
          end
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = BOOT;
    endcase
    imem_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef RETIRE_CNT_EN
      instret_q     <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      imem_req_q    <= imem_req_d;
`ifdef RETIRE_CNT_EN
      instret_q     <= instret_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = misalign_q;
  assign dbg_state   = state_q;
`ifdef RETIRE_CNT_EN
  assign instret     = instret_q;
`endif

endmodule
